// File: rtl/autocorr_control.sv
// Autocorrelation sequencer: walks lags k=0..ORDER, issuing sample-pair addresses
// to the dual-port RAM and gating the external MAC, then writes R[k].
module autocorr_control #(
  parameter int N_SAMPLES = 240,
  parameter int ORDER     = 10,
  parameter int AW        = 8,
  parameter int PIPE_LAT  = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          ready,
  output logic          done,
  output logic [AW-1:0] x_raddr_a,
  output logic [AW-1:0] x_raddr_b,
  output logic          acc_clr,
  output logic          acc_en,
  output logic [3:0]    r_waddr,
  output logic          r_wen
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam int            DW     = $clog2(PIPE_LAT + 1);
  localparam logic [AW-1:0] N_LAST = AW'(N_SAMPLES - 1);
  localparam logic [3:0]    K_LAST = 4'(ORDER);
  localparam logic [DW-1:0] D_LAST = DW'(PIPE_LAT - 1);

  logic [2:0]          state_q, state_d;
  logic [3:0]          k_q, k_d;
  logic [AW-1:0]       n_q, n_d;
  logic [DW-1:0]       drain_q, drain_d;
  logic [PIPE_LAT-1:0] pipe_q, pipe_d;
  logic                issue;

  assign issue = (state_q == S_ADDR);

  // Delay line mirroring the RAM read + multiplier latency; its tail is acc_en.
  always_comb begin
    pipe_d    = pipe_q << 1;
    pipe_d[0] = issue;
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    n_d     = n_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          k_d     = 4'd0;
        end
      end
      S_CLEAR: begin
        n_d     = AW'(k_q);
        drain_d = '0;
        state_d = S_ADDR;
      end
      S_ADDR: begin
        if (n_q == N_LAST) begin
          state_d = S_DRAIN;
        end else begin
          n_d = n_q + AW'(1);
        end
      end
      S_DRAIN: begin
        if (drain_q == D_LAST) begin
          state_d = S_WRITE;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      S_WRITE: begin
        if (k_q == K_LAST) begin
          state_d = S_DONE;
        end else begin
          k_d     = k_q + 4'd1;
          state_d = S_CLEAR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      n_q     <= '0;
      drain_q <= '0;
      pipe_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      n_q     <= n_d;
      drain_q <= drain_d;
      pipe_q  <= pipe_d;
    end
  end

  always_comb begin
    ready     = (state_q == S_IDLE);
    done      = (state_q == S_DONE);
    acc_clr   = (state_q == S_CLEAR);
    acc_en    = pipe_q[PIPE_LAT-1];
    r_wen     = (state_q == S_WRITE);
    r_waddr   = (state_q == S_WRITE) ? k_q : 4'd0;
    x_raddr_a = issue ? n_q : '0;
    x_raddr_b = issue ? (n_q - AW'(k_q)) : '0;
  end

endmodule

// File: tb/tb_autocorr_control.sv
// Scoreboard bench: stimulus pushes expected clear/write/done events with their
// cycle stamps; a negedge monitor pops and compares them against the DUT and a RAM/MAC model.
module tb_autocorr_control;
  localparam int N   = 240;
  localparam int ORD = 10;
  localparam int AW  = 8;
  localparam int P   = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          ready, done, acc_clr, acc_en, r_wen;
  logic [AW-1:0] x_raddr_a, x_raddr_b;
  logic [3:0]    r_waddr;

  autocorr_control #(.N_SAMPLES(N), .ORDER(ORD), .AW(AW), .PIPE_LAT(P)) dut (
    .clk(clk), .reset(reset), .start(start), .ready(ready), .done(done),
    .x_raddr_a(x_raddr_a), .x_raddr_b(x_raddr_b), .acc_clr(acc_clr),
    .acc_en(acc_en), .r_waddr(r_waddr), .r_wen(r_wen)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Sample RAM holds x[n] = n+1; one read register then one multiplier register.
  logic [31:0] ra_q, rb_q;
  logic [63:0] prod_q, acc;
  always @(posedge clk) begin
    ra_q   <= 32'(x_raddr_a) + 32'd1;
    rb_q   <= 32'(x_raddr_b) + 32'd1;
    prod_q <= 64'(ra_q) * 64'(rb_q);
    if (acc_clr)     acc <= 64'd0;
    else if (acc_en) acc <= acc + prod_q;
  end

  typedef struct { int k; int cyc; } clr_t;
  typedef struct { int k; int cyc; longint r; } wr_t;
  clr_t clr_q[$];
  wr_t  wr_q[$];
  int   done_q[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // R[k] = sum_{m=k+1}^{N} m*(m-k); R[0]=4636840 and R[1]=4607920 worked by hand.
  function automatic longint r_ref(input int k);
    longint m, kk, s2, s1;
    if (k == 0) return 64'd4636840;
    if (k == 1) return 64'd4607920;
    m  = N;
    kk = k;
    s2 = m * (m + 1) * (2 * m + 1) / 6 - kk * (kk + 1) * (2 * kk + 1) / 6;
    s1 = m * (m + 1) / 2 - kk * (kk + 1) / 2;
    return s2 - kk * s1;
  endfunction

  // cs is the cycle in which start is seen high; lag k spans 1+(N-k)+P+1 cycles.
  task automatic push_frame(input int cs, input int n_clr, input int n_wr, input bit with_done);
    int t;
    clr_t c;
    wr_t  w;
    t = cs + 1;
    for (int k = 0; k <= ORD; k++) begin
      if (k < n_clr) begin
        c.k = k; c.cyc = t;
        clr_q.push_back(c);
      end
      if (k < n_wr) begin
        w.k = k; w.cyc = t + 1 + (N - k) + P; w.r = r_ref(k);
        wr_q.push_back(w);
      end
      t = t + 1 + (N - k) + P + 1;
    end
    if (with_done) done_q.push_back(t);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  int cur_k = -1;
  int clr_cyc = 0;
  int en_cnt = 0;
  bit quiet = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      if (acc_en) en_cnt++;
      if (quiet) check("quiet_acc_en", acc_en, 0);
      if (acc_clr) begin
        check("clr_en_overlap", acc_en, 0);
        if (clr_q.size() == 0) begin
          check("clr_unexpected", 1, 0);
        end else begin
          clr_t c;
          c = clr_q.pop_front();
          check("clr_cycle", cyc, c.cyc);
          cur_k   = c.k;
          clr_cyc = cyc;
          en_cnt  = 0;
        end
      end
      if (r_wen) begin
        if (wr_q.size() == 0) begin
          check("wen_unexpected", 1, 0);
        end else begin
          wr_t w;
          w = wr_q.pop_front();
          $display("write k=%0d R=%0d acc_en=%0d cycle=%0d", r_waddr, acc, en_cnt, cyc);
          check("wen_cycle", cyc, w.cyc);
          check("r_waddr", r_waddr, w.k);
          check("r_value", acc, w.r);
          check("acc_en_count", en_cnt, N - w.k);
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          check("done_unexpected", 1, 0);
        end else begin
          int d;
          d = done_q.pop_front();
          $display("done cycle=%0d", cyc);
          check("done_cycle", cyc, d);
        end
      end
      if (acc_clr || r_wen || done || ready) begin
        check("addr_a_zero", x_raddr_a, 0);
        check("addr_b_zero", x_raddr_b, 0);
      end
      if (!quiet && cur_k >= 0) begin
        if (cyc == clr_cyc + 1) begin
          check("first_addr_a", x_raddr_a, cur_k);
          check("first_addr_b", x_raddr_b, 0);
        end
        if (cyc == clr_cyc + N - cur_k) begin
          check("last_addr_a", x_raddr_a, N - 1);
          check("last_addr_b", x_raddr_b, N - 1 - cur_k);
        end
        if (cyc > clr_cyc + N - cur_k && cyc <= clr_cyc + N - cur_k + P) begin
          check("drain_addr_a", x_raddr_a, 0);
          check("drain_addr_b", x_raddr_b, 0);
        end
      end
    end
  end

  int cs, cs2, cs3, cs4;

  initial begin
    reset = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_acc_clr", acc_clr, 0);
    check("rst_acc_en", acc_en, 0);
    check("rst_r_wen", r_wen, 0);
    check("rst_r_waddr", r_waddr, 0);
    check("rst_addr_a", x_raddr_a, 0);
    check("rst_addr_b", x_raddr_b, 0);

    // Frame 1 with a stray start during lag 5 ADDR, which must be ignored.
    start = 1'b1;
    cs = cyc;
    push_frame(cs, ORD + 1, ORD + 1, 1'b1);
    wait_to(cs + 1);
    start = 1'b0;
    wait_to(cs + 1300);
    start = 1'b1;
    wait_to(cs + 1301);
    start = 1'b0;

    // start held through DONE: frame 2 starts from the IDLE cycle after done.
    wait_to(cs + 2625);
    start = 1'b1;
    cs2 = cs + 2631;
    push_frame(cs2, ORD + 1, ORD + 1, 1'b1);
    wait_to(cs2 + 3);
    start = 1'b0;

    // Frame 3 is cut by reset during lag 4 ADDR.
    wait_to(cs2 + 2640);
    start = 1'b1;
    cs3 = cyc;
    push_frame(cs3, 5, 4, 1'b0);
    wait_to(cs3 + 1);
    start = 1'b0;
    wait_to(cs3 + 1000);
    reset = 1'b0;
    wait_to(cs3 + 1001);
    reset = 1'b1;
    quiet = 1'b1;
    check("midrst_ready", ready, 1);
    check("midrst_acc_en", acc_en, 0);
    wait_to(cs3 + 1400);
    quiet = 1'b0;
    check("midrst_clr_left", clr_q.size(), 0);
    check("midrst_wr_left", wr_q.size(), 0);

    // Frame 4 runs from k=0 after the interrupted one.
    start = 1'b1;
    cs4 = cyc;
    push_frame(cs4, ORD + 1, ORD + 1, 1'b1);
    wait_to(cs4 + 1);
    start = 1'b0;
    wait_to(cs4 + 2640);
    check("end_clr_left", clr_q.size(), 0);
    check("end_wr_left", wr_q.size(), 0);
    check("end_done_left", done_q.size(), 0);
    check("end_ready", ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
